// File: rtl/dmem_access_pkg.sv
// Shared encodings for the data-memory access path: dm_type codes,
// FSM state encoding and the access-size decode used by both the
// lane formatter and the controller.
package dmem_access_pkg;

  // dm_type encodings as produced by the decoder
  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_B  = 3'b001;
  localparam logic [2:0] DM_H  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b101;
  localparam logic [2:0] DM_HU = 3'b110;

  // Access controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Access size after decoding dm_type
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Reserved codes (011, 100, 111) fall through to word
  function automatic size_t dm_size(input logic [2:0] t);
    case (t)
      DM_B, DM_BU: return SZ_B;
      DM_H, DM_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Purely combinational lane handling for data-memory accesses:
// alignment check, store strobes and lane replication on the request
// side, byte/half extraction with sign or zero extension on the load side.
module dmem_lane_fmt
  import dmem_access_pkg::*;
(
  input  logic [2:0]  i_req_type,
  input  logic [1:0]  i_req_off,
  input  logic [31:0] i_wdata,
  output logic        o_aligned,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata_al,
  input  logic [2:0]  i_ld_type,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_ld_uns;

  // Store side: alignment rule, strobe position and replicated lane data
  always_comb begin
    o_aligned  = 1'b1;
    o_wstrb    = 4'b1111;
    o_wdata_al = i_wdata;
    case (dm_size(i_req_type))
      SZ_B: begin
        o_aligned  = 1'b1;
        o_wstrb    = 4'b0001 << i_req_off;
        o_wdata_al = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        o_aligned  = ~i_req_off[0];
        o_wstrb    = 4'b0011 << {i_req_off[1], 1'b0};
        o_wdata_al = {2{i_wdata[15:0]}};
      end
      default: begin
        o_aligned  = (i_req_off == 2'b00);
        o_wstrb    = 4'b1111;
        o_wdata_al = i_wdata;
      end
    endcase
  end

  // Load side: pick the addressed byte/half and extend; bit 2 selects unsigned
  always_comb begin
    w_byte    = i_ld_word[{i_ld_off, 3'b000} +: 8];
    w_half    = i_ld_word[{i_ld_off[1], 4'b0000} +: 16];
    w_ld_uns  = i_ld_type[2];
    o_ld_data = i_ld_word;
    case (dm_size(i_ld_type))
      SZ_B:    o_ld_data = w_ld_uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_H:    o_ld_data = w_ld_uns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_ld_data = i_ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_access.sv
// MEM-stage data-memory access controller. Freezes the pipeline while a
// single bus transaction is in flight, registers the bus request fields
// for the whole BUSY phase and presents the formatted load result in DONE.
module dmem_access
  import dmem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        dm_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misalign,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  state_t            r_state;
  logic [31:0]       r_rdata;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [3:0]        r_bus_wstrb;
  logic [31:0]       r_bus_wdata;
  logic [2:0]        r_ld_type;
  logic [1:0]        r_ld_off;

  logic              w_req;
  logic              w_aligned;
  logic              w_start;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_wdata_al;
  logic [31:0]       w_ld_data;

  dmem_lane_fmt u_lane_fmt (
    .i_req_type (dm_type),
    .i_req_off  (addr[1:0]),
    .i_wdata    (wdata),
    .o_aligned  (w_aligned),
    .o_wstrb    (w_wstrb),
    .o_wdata_al (w_wdata_al),
    .i_ld_type  (r_ld_type),
    .i_ld_off   (r_ld_off),
    .i_ld_word  (bus_rdata),
    .o_ld_data  (w_ld_data)
  );

  // Request decode: stall must rise in the same cycle the request appears
  always_comb begin
    w_req    = mem_read | mem_write;
    w_start  = (r_state == ST_IDLE) && w_req && w_aligned;
    stall    = w_start || (r_state == ST_BUSY);
    misalign = (r_state == ST_IDLE) && w_req && !w_aligned;
    bus_req  = (r_state == ST_BUSY);
    rdata    = (r_state == ST_DONE) ? r_rdata : 32'b0;
  end

  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wstrb = r_bus_wstrb;
  assign bus_wdata = r_bus_wdata;

  // Controller FSM with registered bus fields and load result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rdata     <= 32'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wstrb <= 4'b0;
      r_bus_wdata <= 32'b0;
      r_ld_type   <= DM_W;
      r_ld_off    <= 2'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            // A store wins when both request lines are high
            r_bus_we    <= mem_write;
            r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            r_bus_wstrb <= mem_write ? w_wstrb : 4'b0;
            r_bus_wdata <= mem_write ? w_wdata_al : 32'b0;
            r_ld_type   <= dm_type;
            r_ld_off    <= addr[1:0];
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus_ready) begin
            r_rdata <= r_bus_we ? 32'b0 : w_ld_data;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Request inputs still belong to the retiring instruction
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access.sv
// Self-checking bench for dmem_access: directed scenarios followed by
// randomized accesses scored against an arithmetic reference model.
module tb_dmem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  dm_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_access #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .dm_type   (dm_type),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .misalign  (misalign),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wstrb (bus_wstrb),
    .bus_wdata (bus_wdata),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata)
  );

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] t);
    if (t == 3'b001 || t == 3'b101) return 1;
    if (t == 3'b010 || t == 3'b110) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] t, input logic [31:0] a);
    int sz = size_of(t);
    if (sz == 1) return 4'(1 << (a % 4));
    if (sz == 2) return 4'(3 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] t, input logic [31:0] wd);
    int sz = size_of(t);
    if (sz == 1) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] t, input logic [31:0] a,
                                           input logic [31:0] word);
    int sz = size_of(t);
    logic [31:0] v = word >> (8 * (a % 4));
    bit is_signed = (t == 3'b001 || t == 3'b010);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (is_signed && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (is_signed && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete access; entered and left just after a rising edge.
  task automatic access(input string tag, input bit rd, input bit wr, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] word, input int waits);
    int          nstall;
    bit          al;
    logic [31:0] exp_rd;
    al     = (a % size_of(t)) == 0;
    exp_rd = wr ? 32'h0 : exp_load(t, a, word);
    mem_read  = rd;
    mem_write = wr;
    dm_type   = t;
    addr      = a;
    wdata     = wd;
    bus_rdata = $urandom();
    bus_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (!al) begin
      chk({tag, "_misalign"}, 32'(misalign), 32'h1);
      chk({tag, "_mis_stall"}, 32'(stall), 32'h0);
      chk({tag, "_mis_busreq"}, 32'(bus_req), 32'h0);
      chk({tag, "_mis_rdata"}, rdata, 32'h0);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; bus_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_mis_clear"}, 32'(misalign), 32'h0);
      chk({tag, "_mis_idle_req"}, 32'(bus_req), 32'h0);
      @(posedge clk); #1;
      return;
    end
    chk({tag, "_misalign0"}, 32'(misalign), 32'h0);
    chk({tag, "_stall_first"}, 32'(stall), 32'h1);
    chk({tag, "_busreq_first"}, 32'(bus_req), 32'h0);
    nstall = int'(stall);
    for (int c = 0; c <= waits; c++) begin
      @(posedge clk); #1;
      bus_ready = (c == waits);
      bus_rdata = (c == waits) ? word : $urandom();
      @(negedge clk);
      nstall += int'(stall);
      chk({tag, "_busreq"}, 32'(bus_req), 32'h1);
      chk({tag, "_bus_we"}, 32'(bus_we), 32'(wr));
      chk({tag, "_bus_addr"}, bus_addr, a & 32'hFFFF_FFFC);
      if (wr) begin
        chk({tag, "_wstrb"}, 32'(bus_wstrb), 32'(exp_strb(t, a)));
        chk({tag, "_wdata"}, bus_wdata, exp_wdata(t, wd));
      end
    end
    @(posedge clk); #1;
    bus_ready = 1'($urandom_range(0, 1));
    bus_rdata = $urandom();
    @(negedge clk);
    nstall += int'(stall);
    chk({tag, "_done_stall"}, 32'(stall), 32'h0);
    chk({tag, "_done_busreq"}, 32'(bus_req), 32'h0);
    chk({tag, "_rdata"}, rdata, exp_rd);
    chk({tag, "_stall_cycles"}, 32'(nstall), 32'(waits + 2));
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    bus_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk({tag, "_idle_busreq"}, 32'(bus_req), 32'h0);
    chk({tag, "_idle_stall"}, 32'(stall), 32'h0);
    @(posedge clk); #1;
    bus_ready = 1'b0;
  endtask

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [2:0] codes [8] = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110, 3'b011, 3'b100, 3'b111};

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; dm_type = 3'b000;
    addr = 32'h0; wdata = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    chk("rst_busreq", 32'(bus_req), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bus_we", 32'(bus_we), 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_wstrb", 32'(bus_wstrb), 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    @(posedge clk); #1;

    // Directed scenarios
    access("lw104", 1'b1, 1'b0, 3'b000, 32'h104, 32'h0, 32'hDEADBEEF, 0);
    access("lb103", 1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 32'h80FF0011, 0);
    access("lbu103", 1'b1, 1'b0, 3'b101, 32'h103, 32'h0, 32'h80FF0011, 0);
    access("sh102", 1'b0, 1'b1, 3'b010, 32'h102, 32'h0000ABCD, 32'h0, 0);
    access("sb101", 1'b0, 1'b1, 3'b001, 32'h101, 32'h12345678, 32'h0, 1);
    access("lw106", 1'b1, 1'b0, 3'b000, 32'h106, 32'h0, 32'h0, 0);
    access("lh103", 1'b1, 1'b0, 3'b010, 32'h103, 32'h0, 32'h0, 0);
    access("lw_wait3", 1'b1, 1'b0, 3'b000, 32'h208, 32'h0, 32'hCAFEF00D, 3);
    access("sw_rdwr", 1'b1, 1'b1, 3'b000, 32'h20C, 32'h5A5AA5A5, 32'h11111111, 2);
    access("lhu_rsvd", 1'b1, 1'b0, 3'b110, 32'h302, 32'h0, 32'h8001F00F, 0);
    access("rsvd100", 1'b1, 1'b0, 3'b100, 32'h310, 32'h0, 32'h87654321, 0);

    // Reset in the second BUSY cycle aborts the access
    mem_read = 1'b1; mem_write = 1'b0; dm_type = 3'b000; addr = 32'h400; bus_ready = 1'b0;
    @(negedge clk);
    chk("rstb_stall", 32'(stall), 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstb_busreq_before", 32'(bus_req), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    chk("rstb_busreq_after", 32'(bus_req), 32'h0);
    chk("rstb_stall_after", 32'(stall), 32'h0);
    chk("rstb_rdata", rdata, 32'h0);
    chk("rstb_bus_we", 32'(bus_we), 32'h0);
    chk("rstb_bus_addr", bus_addr, 32'h0);
    @(posedge clk); #1;
    access("lw_after_rst", 1'b1, 1'b0, 3'b000, 32'h404, 32'h0, 32'h0BADF00D, 0);

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  t;
      bit          rd;
      bit          wr;
      t  = codes[$urandom_range(0, 7)];
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      access("rand", rd, wr, t, 32'h1000 + 32'($urandom_range(0, 255)),
             $urandom(), $urandom(), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
